alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, registered successor to the i281 combinational ALU. Adds carry-chained ops (ADC/SBB), multi-bit shift and shift-add multiply, plus a start/busy/done handshake.
- Sits between register file and flags register in the next-gen datapath. Control FSM issues one op per start and stalls on busy.
- Keeps the existing flag packing: alu_flags = {C, Z, N, V}.

Parameters:
- WIDTH, 8, datapath width in bits; must be >= 4.
- CNT_W, $clog2(WIDTH), width of shift amount and step counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  3  000 SHL1, 001 ADD, 010 SHR1, 011 SUB, 100 ADC, 101 SBB, 110 SHLN, 111 MUL
- alu_in_one  input  WIDTH  operand A
- alu_in_two  input  WIDTH  operand B; for SHLN, B[CNT_W-1:0] is the shift amount n
- busy  output  1  high while an accepted op is in progress (RUN state)
- done  output  1  one-cycle pulse; result and flags valid from this cycle
- alu_result  output  WIDTH  registered result, held until next done
- alu_flags  output  4  registered {C,Z,N,V}, held until next done

Behaviour:
- Reset (synchronous, priority over everything):
  - state=IDLE; busy=0, done=0, alu_result=0, alu_flags=0; internal counter and accumulators cleared.
  - Reset during RUN aborts the op; no done is issued.
- States and transitions:
  - IDLE: start=1 latches op, A, B, and the current C flag (carry-in). Goes to DONE for single-step ops, to RUN for SHLN with n>0 and for MUL.
  - RUN: busy=1; one step per cycle; counter decrements; goes to DONE after the last step. start is ignored.
  - DONE: done=1 for exactly one cycle; result and flags registers update on entry. Next state is IDLE. start is ignored here, so the minimum issue interval is 2 cycles.
- Latency L (start edge to first cycle with done=1):
  - SHL1, ADD, SHR1, SUB, ADC, SBB, and SHLN with n=0: L=1.
  - SHLN with n>0: L=1+n.
  - MUL: L=WIDTH+1.
- Arithmetic is (WIDTH+1)-bit zero-padded; result = low WIDTH bits. Z = (result==0), N = result[WIDTH-1] for all ops.
- Per-op rules:
  - SHL1: C=A[MSB], V=0.
  - SHR1: logical shift; C=A[0], V=0.
  - ADD: C = bit WIDTH of the sum; V = (A,B same sign) and (result sign != A sign).
  - ADC: as ADD, plus the latched carry-in.
  - SUB: {0,A}-{0,B}; C = bit WIDTH (borrow); V = (A,B differ in sign) and (result sign != A sign).
  - SBB: as SUB, minus the latched carry-in.
  - SHLN: shift left one bit per RUN cycle; C = last bit shifted out (0 if n=0); V=0. n >= WIDTH is impossible by port width.
  - MUL: unsigned shift-add, one partial product per RUN cycle; result = low WIDTH bits of the 2*WIDTH product; C = (high half != 0); V=0.
- Boundaries:
  - Operands changing after acceptance have no effect.
  - A start pulse in RUN or DONE is dropped, not queued.
  - Flags are never modified except at done.

Optional Feature:
- Macro ALU_SIGNED_MUL_EN.
- Defined: MUL treats A and B as two's complement. It multiplies magnitudes and negates the product if the signs differ. Latency is unchanged (WIDTH+1). C=0; V=1 if the full product does not fit in signed WIDTH bits.
- Undefined: MUL is unsigned as specified above; no sign logic is synthesised.

Test Plan (WIDTH=8):
- reset high for 2 cycles, then start ADD A=0x7F B=0x01 -> done at L=1; result=0x80, flags C0 Z0 N1 V1 = 4'b0011.
- SUB A=0x00 B=0x01 -> result=0xFF, flags 4'b1010. Then ADC A=0x01 B=0x01 -> carry-in 1, result=0x03, flags 4'b0000.
- SHLN A=0x81 B=0x03 -> busy for 3 cycles, done at L=4; result=0x08, C=0 (last bit out). SHLN with B=0x00 -> L=1, result=A, C=0.
- MUL A=0x10 B=0x11 -> done at L=9; result=0x10, C=1. With ALU_SIGNED_MUL_EN: A=0xFE B=0x03 -> result=0xFA, V=0.
- start pulsed every cycle during MUL -> exactly one done; subsequent op accepted only once back in IDLE.
- reset asserted at RUN cycle 4 of MUL -> no done, all outputs 0 next cycle; new ADD afterwards completes normally with L=1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU with a start/busy/done handshake.
// Single-step ops finish in 1 cycle, SHLN takes 1+n cycles and MUL takes WIDTH+1 cycles.
// Optional macro ALU_SIGNED_MUL_EN makes MUL a signed two's-complement multiply.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] alu_in_one,
  input  logic [WIDTH-1:0] alu_in_two,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_result,
  output logic [3:0]       alu_flags
);

  typedef enum logic [2:0] {
    OP_SHL1 = 3'b000,
    OP_ADD  = 3'b001,
    OP_SHR1 = 3'b010,
    OP_SUB  = 3'b011,
    OP_ADC  = 3'b100,
    OP_SBB  = 3'b101,
    OP_SHLN = 3'b110,
    OP_MUL  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t state;
  state_t next_state;

  // Latched operation context for multi-cycle ops.
  logic [2:0]         op_q;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc;    // SHLN shift register, or MUL multiplicand
  logic [2*WIDTH-1:0] prod;   // MUL {partial high half, remaining multiplier bits}
`ifdef ALU_SIGNED_MUL_EN
  logic               neg_q;  // product must be negated at the end
`endif

  // FSM control strobes.
  logic accept;
  logic step;
  logic last_step;

  // Carry-in is the C flag as it stands when the op is accepted.
  logic             cin;
  logic [CNT_W-1:0] shamt;
  assign cin   = alu_flags[3];
  assign shamt = alu_in_two[CNT_W-1:0];

  // ---------------- single-step datapath ----------------
  logic [WIDTH:0]   ext_a;
  logic [WIDTH:0]   ext_b;
  logic [WIDTH:0]   ext_cin;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] ss_res;
  logic             ss_c;
  logic             ss_v;
  logic [3:0]       ss_flags;
  logic             a_msb;
  logic             b_msb;

  assign ext_a = {1'b0, alu_in_one};
  assign ext_b = {1'b0, alu_in_two};
  assign a_msb = alu_in_one[WIDTH-1];
  assign b_msb = alu_in_two[WIDTH-1];

  // Combinational result and flags of every op that completes in one cycle.
  always_comb begin
    ss_res  = '0;
    ss_c    = 1'b0;
    ss_v    = 1'b0;
    wide    = '0;
    ext_cin = '0;
    case (op_t'(op))
      OP_SHL1: begin
        ss_res = {alu_in_one[WIDTH-2:0], 1'b0};
        ss_c   = alu_in_one[WIDTH-1];
      end
      OP_SHR1: begin
        ss_res = {1'b0, alu_in_one[WIDTH-1:1]};
        ss_c   = alu_in_one[0];
      end
      OP_ADD, OP_ADC: begin
        ext_cin = {{WIDTH{1'b0}}, (op == OP_ADC) & cin};
        wide    = ext_a + ext_b + ext_cin;
        ss_res  = wide[WIDTH-1:0];
        ss_c    = wide[WIDTH];
        ss_v    = (a_msb == b_msb) && (wide[WIDTH-1] != a_msb);
      end
      OP_SUB, OP_SBB: begin
        ext_cin = {{WIDTH{1'b0}}, (op == OP_SBB) & cin};
        wide    = ext_a - ext_b - ext_cin;
        ss_res  = wide[WIDTH-1:0];
        ss_c    = wide[WIDTH];
        ss_v    = (a_msb != b_msb) && (wide[WIDTH-1] != a_msb);
      end
      OP_SHLN: begin
        // Only reached as a single-step op when n == 0: pass A through.
        ss_res = alu_in_one;
        ss_c   = 1'b0;
      end
      default: begin
        ss_res = '0;
      end
    endcase
    ss_flags = {ss_c, (ss_res == '0), ss_res[WIDTH-1], ss_v};
  end

  // ---------------- multi-cycle datapath ----------------
  logic [WIDTH-1:0]   shl_nxt;
  logic               shl_c;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [2*WIDTH-1:0] mul_final;
  logic [WIDTH-1:0]   run_res;
  logic               run_c;
  logic               run_v;
  logic [3:0]         run_flags;
  logic [WIDTH-1:0]   a_load;
  logic [WIDTH-1:0]   b_load;
`ifdef ALU_SIGNED_MUL_EN
  logic               mul_neg;
  logic [WIDTH:0]     top_bits;
`endif

  // Operands loaded into the multiplier (magnitudes when multiplying signed).
  always_comb begin
`ifdef ALU_SIGNED_MUL_EN
    a_load  = alu_in_one[WIDTH-1] ? (~alu_in_one + 1'b1) : alu_in_one;
    b_load  = alu_in_two[WIDTH-1] ? (~alu_in_two + 1'b1) : alu_in_two;
    mul_neg = alu_in_one[WIDTH-1] ^ alu_in_two[WIDTH-1];
`else
    a_load  = alu_in_one;
    b_load  = alu_in_two;
`endif
  end

  // One SHLN shift / one MUL partial product per RUN cycle, plus final flags.
  always_comb begin
    shl_nxt   = {acc[WIDTH-2:0], 1'b0};
    shl_c     = acc[WIDTH-1];
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, acc} : '0);
    mul_nxt   = {mul_sum, prod[WIDTH-1:1]};
    mul_final = mul_nxt;
    run_res   = '0;
    run_c     = 1'b0;
    run_v     = 1'b0;
`ifdef ALU_SIGNED_MUL_EN
    top_bits  = '0;
`endif
    if (op_q == OP_MUL) begin
`ifdef ALU_SIGNED_MUL_EN
      mul_final = neg_q ? (~mul_nxt + 1'b1) : mul_nxt;
      top_bits  = mul_final[2*WIDTH-1:WIDTH-1];
      run_res   = mul_final[WIDTH-1:0];
      run_c     = 1'b0;
      // Fits in signed WIDTH bits only if the upper bits are a pure sign extension.
      run_v     = !((&top_bits) || (~|top_bits));
`else
      run_res   = mul_final[WIDTH-1:0];
      run_c     = |mul_final[2*WIDTH-1:WIDTH];
      run_v     = 1'b0;
`endif
    end else begin
      run_res = shl_nxt;
      run_c   = shl_c;
      run_v   = 1'b0;
    end
    run_flags = {run_c, (run_res == '0), run_res[WIDTH-1], run_v};
  end

  // ---------------- control FSM ----------------
  // State register; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    step       = 1'b0;
    last_step  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if ((op == OP_MUL) || ((op == OP_SHLN) && (shamt != '0))) begin
            next_state = S_RUN;
          end else begin
            next_state = S_DONE;
          end
        end
      end
      S_RUN: begin
        busy      = 1'b1;
        step      = 1'b1;
        last_step = (cnt == '0);
        if (cnt == '0) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Operand capture, per-cycle stepping and result/flag writeback on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= '0;
      cnt        <= '0;
      acc        <= '0;
      prod       <= '0;
      alu_result <= '0;
      alu_flags  <= '0;
`ifdef ALU_SIGNED_MUL_EN
      neg_q      <= 1'b0;
`endif
    end else if (accept) begin
      op_q <= op;
      if (op == OP_MUL) begin
        acc  <= a_load;
        prod <= {{WIDTH{1'b0}}, b_load};
        cnt  <= CNT_W'(WIDTH - 1);
`ifdef ALU_SIGNED_MUL_EN
        neg_q <= mul_neg;
`endif
      end else if ((op == OP_SHLN) && (shamt != '0)) begin
        acc <= alu_in_one;
        cnt <= shamt - CNT_W'(1);
      end else begin
        alu_result <= ss_res;
        alu_flags  <= ss_flags;
      end
    end else if (step) begin
      cnt <= cnt - CNT_W'(1);
      if (op_q == OP_MUL) begin
        prod <= mul_nxt;
      end else begin
        acc <= shl_nxt;
      end
      if (last_step) begin
        alu_result <= run_res;
        alu_flags  <= run_flags;
      end
    end
  end

endmodule
